// File: rtl/mem_wb_stage_pkg.sv
// Shared MEM/WB definitions: write-back source codes, load funct3 codes and
// default datapath widths.
package mem_wb_stage_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RAW_DEF  = 5;

    typedef enum logic [1:0] {
        WDSEL_ALU = 2'b00,
        WDSEL_MEM = 2'b01,
        WDSEL_PC4 = 2'b10,
        WDSEL_RSV = 2'b11
    } wdsel_t;

    localparam logic [2:0] DM_LB  = 3'b000;
    localparam logic [2:0] DM_LH  = 3'b001;
    localparam logic [2:0] DM_LW  = 3'b010;
    localparam logic [2:0] DM_LBU = 3'b100;
    localparam logic [2:0] DM_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Load byte/halfword extraction with sign/zero extension and a misalignment
// flag. Purely combinational.
module load_ext
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] memdata,
    input  logic [2:0]      dmtype,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = memdata[{addr_lo, 3'b000} +: 8];
        half_v     = memdata[{addr_lo[1], 4'b0000} +: 16];
        data       = memdata;
        misaligned = 1'b0;
        unique case (dmtype)
            DM_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
            DM_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
            DM_LH: begin
                data       = {{(XLEN-16){half_v[15]}}, half_v};
                misaligned = addr_lo[0];
            end
            DM_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_v};
                misaligned = addr_lo[0];
            end
            // LW and every undefined code: whole word, must be word aligned
            default: begin
                data       = memdata;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back formatter driving the register-file
// write port, the forwarding bus and a retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned RAW  = RAW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_rfwr,
    input  logic [RAW-1:0]  in_rd,
    input  logic [1:0]      in_wdsel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [XLEN-1:0] in_memdata,
    input  logic [2:0]      in_dmtype,
    input  logic [1:0]      in_addr_lo,
    output logic            rf_wr,
    output logic [RAW-1:0]  rf_a3,
    output logic [XLEN-1:0] rf_wd,
    output logic            fwd_valid,
    output logic [RAW-1:0]  fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            misalign_err,
    output logic [31:0]     retire_cnt
);

    wdsel_t          wdsel;
    logic [XLEN-1:0] ld_data;
    logic            ld_mis;
    logic            mis;
    logic            wr_next;
    logic [XLEN-1:0] wd_next;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .memdata    (in_memdata),
        .dmtype     (in_dmtype),
        .addr_lo    (in_addr_lo),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    assign wdsel = wdsel_t'(in_wdsel);

    always_comb begin
        // Alignment only matters for a real load that writes back
        mis     = in_valid & in_rfwr & (wdsel == WDSEL_MEM) & ld_mis;
        wr_next = in_valid & in_rfwr & (in_rd != '0) & ~mis;
        unique case (wdsel)
            WDSEL_MEM: wd_next = ld_data;
            WDSEL_PC4: wd_next = in_pc4;
            default:   wd_next = in_alu;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr        <= 1'b0;
            rf_a3        <= '0;
            rf_wd        <= '0;
            misalign_err <= 1'b0;
            retire_cnt   <= '0;
        end else if (flush) begin
            rf_wr        <= 1'b0;
            rf_a3        <= '0;
            rf_wd        <= '0;
            misalign_err <= 1'b0;
        end else if (!stall) begin
            rf_wr        <= wr_next;
            rf_a3        <= in_rd;
            rf_wd        <= wd_next;
            misalign_err <= mis;
            if (in_valid && !mis)
                retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign fwd_valid = rf_wr;
    assign fwd_rd    = rf_a3;
    assign fwd_data  = rf_wd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed table-driven bench for mem_wb_stage plus hand sequences for stall,
// flush, asynchronous reset and counter wrap.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_rfwr;
    logic [4:0]  in_rd;
    logic [1:0]  in_wdsel;
    logic [31:0] in_alu;
    logic [31:0] in_pc4;
    logic [31:0] in_memdata;
    logic [2:0]  in_dmtype;
    logic [1:0]  in_addr_lo;
    logic        rf_wr;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        misalign_err;
    logic [31:0] retire_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_cnt;

    mem_wb_stage #(.XLEN(32), .RAW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_rfwr      (in_rfwr),
        .in_rd        (in_rd),
        .in_wdsel     (in_wdsel),
        .in_alu       (in_alu),
        .in_pc4       (in_pc4),
        .in_memdata   (in_memdata),
        .in_dmtype    (in_dmtype),
        .in_addr_lo   (in_addr_lo),
        .rf_wr        (rf_wr),
        .rf_a3        (rf_a3),
        .rf_wd        (rf_wd),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .misalign_err (misalign_err),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid;
        logic        rfwr;
        logic [4:0]  rd;
        logic [1:0]  wdsel;
        logic [2:0]  dmtype;
        logic [31:0] memdata;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        exp_wr;
        logic [31:0] exp_wd;
        logic        exp_err;
        logic        exp_inc;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic valid, logic rfwr, logic [4:0] rd,
                                logic [1:0] wdsel, logic [2:0] dmtype,
                                logic [31:0] memdata, logic [31:0] alu,
                                logic [31:0] pc4, logic exp_wr,
                                logic [31:0] exp_wd, logic exp_err,
                                logic exp_inc);
        vec_t v;
        v.valid = valid;   v.rfwr = rfwr;     v.rd = rd;
        v.wdsel = wdsel;   v.dmtype = dmtype; v.memdata = memdata;
        v.alu = alu;       v.pc4 = pc4;       v.exp_wr = exp_wr;
        v.exp_wd = exp_wd; v.exp_err = exp_err; v.exp_inc = exp_inc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=0x%08h req=0x%08h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid   = v.valid;
        in_rfwr    = v.rfwr;
        in_rd      = v.rd;
        in_wdsel   = v.wdsel;
        in_dmtype  = v.dmtype;
        in_memdata = v.memdata;
        in_alu     = v.alu;
        in_addr_lo = v.alu[1:0];
        in_pc4     = v.pc4;
    endtask

    task automatic idle();
        in_valid = 0; in_rfwr = 0; in_rd = '0; in_wdsel = 2'b00;
        in_dmtype = 3'b010; in_memdata = '0; in_alu = '0;
        in_addr_lo = '0; in_pc4 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rf_wr"}, {31'd0, rf_wr}, 32'd0);
        chk({tag, ".rf_a3"}, {27'd0, rf_a3}, 32'd0);
        chk({tag, ".rf_wd"}, rf_wd, 32'd0);
        chk({tag, ".fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
        chk({tag, ".fwd_data"}, fwd_data, 32'd0);
        chk({tag, ".misalign_err"}, {31'd0, misalign_err}, 32'd0);
        chk({tag, ".retire_cnt"}, retire_cnt, 32'd0);
    endtask

    localparam logic [31:0] MD = 32'h80FF7F01;

    initial begin
        // fields: valid rfwr rd wdsel dmtype memdata alu pc4 | wr wd err inc
        vecs[0]  = mk(1, 1, 5, 2'b01, 3'b000, MD, 32'h103, 0, 1, 32'hFFFFFF80, 0, 1);
        vecs[1]  = mk(1, 1, 5, 2'b01, 3'b100, MD, 32'h103, 0, 1, 32'h00000080, 0, 1);
        vecs[2]  = mk(1, 1, 6, 2'b01, 3'b101, MD, 32'h102, 0, 1, 32'h000080FF, 0, 1);
        vecs[3]  = mk(1, 1, 6, 2'b01, 3'b001, MD, 32'h102, 0, 1, 32'hFFFF80FF, 0, 1);
        vecs[4]  = mk(1, 1, 6, 2'b01, 3'b001, MD, 32'h100, 0, 1, 32'h00007F01, 0, 1);
        vecs[5]  = mk(1, 1, 9, 2'b01, 3'b000, MD, 32'h101, 0, 1, 32'h0000007F, 0, 1);
        vecs[6]  = mk(1, 1, 9, 2'b01, 3'b000, MD, 32'h102, 0, 1, 32'hFFFFFFFF, 0, 1);
        vecs[7]  = mk(1, 1, 7, 2'b01, 3'b010, MD, 32'h100, 0, 1, 32'h80FF7F01, 0, 1);
        vecs[8]  = mk(1, 1, 7, 2'b01, 3'b010, MD, 32'h102, 0, 0, 32'h0, 1, 0);
        vecs[9]  = mk(1, 1, 7, 2'b01, 3'b001, MD, 32'h101, 0, 0, 32'h0, 1, 0);
        vecs[10] = mk(1, 1, 7, 2'b01, 3'b101, MD, 32'h103, 0, 0, 32'h0, 1, 0);
        vecs[11] = mk(1, 1, 0, 2'b00, 3'b010, MD, 32'h1234, 0, 0, 32'h0, 0, 1);
        vecs[12] = mk(1, 1, 1, 2'b10, 3'b010, MD, 32'h55, 32'h104, 1, 32'h00000104, 0, 1);
        vecs[13] = mk(1, 1, 2, 2'b11, 3'b010, MD, 32'hCAFEF00D, 32'h8, 1, 32'hCAFEF00D, 0, 1);
        vecs[14] = mk(1, 1, 4, 2'b01, 3'b011, MD, 32'h200, 0, 1, 32'h80FF7F01, 0, 1);
        vecs[15] = mk(0, 1, 9, 2'b00, 3'b010, MD, 32'h77, 0, 0, 32'h0, 0, 0);
        vecs[16] = mk(1, 0, 9, 2'b01, 3'b010, MD, 32'h102, 0, 0, 32'h0, 0, 1);
        vecs[17] = mk(1, 1, 8, 2'b00, 3'b010, MD, 32'h12, 0, 1, 32'h00000012, 0, 1);

        rst = 1; stall = 0; flush = 0;
        idle();
        #2;
        chk_all_zero("reset");
        #6 rst = 0;
        exp_cnt = '0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i]);
            tick();
            if (vecs[i].exp_inc) exp_cnt = exp_cnt + 32'd1;
            chk($sformatf("v%0d.rf_wr", i), {31'd0, rf_wr}, {31'd0, vecs[i].exp_wr});
            chk($sformatf("v%0d.fwd_valid", i), {31'd0, fwd_valid}, {31'd0, vecs[i].exp_wr});
            chk($sformatf("v%0d.misalign_err", i), {31'd0, misalign_err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d.retire_cnt", i), retire_cnt, exp_cnt);
            if (vecs[i].exp_wr) begin
                chk($sformatf("v%0d.rf_a3", i), {27'd0, rf_a3}, {27'd0, vecs[i].rd});
                chk($sformatf("v%0d.rf_wd", i), rf_wd, vecs[i].exp_wd);
                chk($sformatf("v%0d.fwd_rd", i), {27'd0, fwd_rd}, {27'd0, vecs[i].rd});
                chk($sformatf("v%0d.fwd_data", i), fwd_data, vecs[i].exp_wd);
            end
        end

        // stall holds an ALU write to x3 for three cycles
        drive(mk(1, 1, 3, 2'b00, 3'b010, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        tick();
        exp_cnt = exp_cnt + 32'd1;
        chk("stall.pre.rf_wd", rf_wd, 32'hDEADBEEF);
        stall = 1;
        drive(mk(1, 1, 10, 2'b00, 3'b010, 0, 32'h1111, 0, 0, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d.rf_wr", c), {31'd0, rf_wr}, 32'd1);
            chk($sformatf("stall%0d.rf_a3", c), {27'd0, rf_a3}, 32'd3);
            chk($sformatf("stall%0d.rf_wd", c), rf_wd, 32'hDEADBEEF);
            chk($sformatf("stall%0d.retire_cnt", c), retire_cnt, exp_cnt);
        end

        // misalign_err holds through a stall
        stall = 0;
        drive(mk(1, 1, 7, 2'b01, 3'b010, MD, 32'h102, 0, 0, 0, 0, 0));
        tick();
        chk("mis_stall.pre.err", {31'd0, misalign_err}, 32'd1);
        stall = 1;
        drive(mk(1, 1, 12, 2'b00, 3'b010, 0, 32'h4, 0, 0, 0, 0, 0));
        tick();
        chk("mis_stall.err", {31'd0, misalign_err}, 32'd1);
        chk("mis_stall.retire_cnt", retire_cnt, exp_cnt);

        // flush together with stall captures a bubble
        flush = 1;
        drive(mk(1, 1, 11, 2'b00, 3'b010, 0, 32'h99, 0, 0, 0, 0, 0));
        tick();
        chk("flush.rf_wr", {31'd0, rf_wr}, 32'd0);
        chk("flush.rf_a3", {27'd0, rf_a3}, 32'd0);
        chk("flush.rf_wd", rf_wd, 32'd0);
        chk("flush.misalign_err", {31'd0, misalign_err}, 32'd0);
        chk("flush.retire_cnt", retire_cnt, exp_cnt);
        flush = 0; stall = 0;

        // asynchronous reset mid-run while rf_wr is high
        drive(mk(1, 1, 5, 2'b00, 3'b010, 0, 32'h55, 0, 0, 0, 0, 0));
        tick();
        exp_cnt = exp_cnt + 32'd1;
        chk("prerst.rf_wr", {31'd0, rf_wr}, 32'd1);
        chk("prerst.retire_cnt", retire_cnt, exp_cnt);
        idle();
        #2 rst = 1;
        #1;
        chk_all_zero("midrst");
        #1 rst = 0;
        exp_cnt = '0;

        // counter wrap from all-ones
        tick();
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1 release dut.retire_cnt;
        drive(mk(1, 1, 0, 2'b00, 3'b010, 0, 32'h8, 0, 0, 0, 0, 0));
        tick();
        chk("wrap.retire_cnt", retire_cnt, 32'h0000_0000);
        tick();
        chk("wrap.next.retire_cnt", retire_cnt, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
